// File: rtl/spaceship_turn_ctrl.sv
// Turn sequencer: debounces the rotate buttons, adds hold-to-repeat and shortest-path
// autopilot seeking, and emits spaced single-cycle turn pulses to the heading register.
module spaceship_turn_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int STEP_GAP        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_cw,
    input  logic       btn_ccw,
    input  logic       auto_en,
    input  logic       auto_req,
    input  logic [3:0] auto_target,
    input  logic [3:0] angle_in,
    output logic       turn_cw,
    output logic       turn_ccw,
    output logic       busy,
    output logic       auto_done,
    output logic       auto_abort
);

    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RTW  = $clog2(RMAX + 1);
    localparam int GW   = (STEP_GAP > 2) ? $clog2(STEP_GAP) : 1;

    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RTW-1:0] RPT_DLY  = RTW'(REPEAT_DELAY);
    localparam logic [RTW-1:0] RPT_PER  = RTW'(REPEAT_PERIOD);
    localparam logic [GW-1:0]  GAP_LOAD = GW'(STEP_GAP - 1);

    typedef enum logic [1:0] {IDLE, MAN_REPEAT, SEEK, GAP} state_t;

    // index 0 = clockwise button, index 1 = counter-clockwise button
    logic [1:0]     sync1, sync2, db, db_prev, rise;
    logic [DBW-1:0] db_cnt [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            db_prev <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= {btn_ccw, btn_cw};
            sync2   <= sync1;
            db_prev <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= ~db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise = db & ~db_prev;

    state_t         state_q, state_d;
    logic [RTW-1:0] rpt_q, rpt_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [3:0]     tgt_q, tgt_d;
    logic           dir_q, dir_d;
    logic           cw_d, ccw_d, done_d, abort_d;
    logic [3:0]     diff;
    logic           gap_ok, held, cancel;

    assign diff   = tgt_q - angle_in;
    assign gap_ok = (gap_q == '0);
    assign held   = (db == (dir_q ? 2'b10 : 2'b01));
    assign cancel = (db != 2'b00) || !auto_en;

    always_comb begin
        state_d = state_q;
        rpt_d   = rpt_q;
        gap_d   = gap_ok ? gap_q : gap_q - 1'b1;
        tgt_d   = tgt_q;
        dir_d   = dir_q;
        cw_d    = 1'b0;
        ccw_d   = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                // a press landing inside the spacing window of a prior pulse is dropped
                if (rise[0] && !db[1] && gap_ok) begin
                    cw_d    = 1'b1;
                    dir_d   = 1'b0;
                    rpt_d   = RPT_DLY;
                    state_d = MAN_REPEAT;
                end else if (rise[1] && !db[0] && gap_ok) begin
                    ccw_d   = 1'b1;
                    dir_d   = 1'b1;
                    rpt_d   = RPT_DLY;
                    state_d = MAN_REPEAT;
                end else if (auto_req && auto_en && db == 2'b00) begin
                    tgt_d   = auto_target;
                    state_d = SEEK;
                end
            end
            MAN_REPEAT: begin
                if (!held) begin
                    state_d = IDLE;
                end else if (rpt_q <= RTW'(1)) begin
                    if (gap_ok) begin
                        cw_d  = !dir_q;
                        ccw_d = dir_q;
                        rpt_d = RPT_PER;
                    end
                end else begin
                    rpt_d = rpt_q - 1'b1;
                end
            end
            SEEK: begin
                if (cancel) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (diff == 4'd0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (gap_ok) begin
                    cw_d    = (diff <= 4'd8);
                    ccw_d   = (diff > 4'd8);
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cancel) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (gap_q <= GW'(1)) begin
                    state_d = SEEK;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cw_d || ccw_d) gap_d = GAP_LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rpt_q      <= '0;
            gap_q      <= '0;
            tgt_q      <= '0;
            dir_q      <= 1'b0;
            turn_cw    <= 1'b0;
            turn_ccw   <= 1'b0;
            busy       <= 1'b0;
            auto_done  <= 1'b0;
            auto_abort <= 1'b0;
        end else begin
            state_q    <= state_d;
            rpt_q      <= rpt_d;
            gap_q      <= gap_d;
            tgt_q      <= tgt_d;
            dir_q      <= dir_d;
            turn_cw    <= cw_d;
            turn_ccw   <= ccw_d;
            busy       <= (state_d != IDLE);
            auto_done  <= done_d;
            auto_abort <= abort_d;
        end
    end

endmodule

// File: tb/tb_spaceship_turn_ctrl.sv
// Directed + randomized bench for spaceship_turn_ctrl; expected pulse schedules are
// derived from the debounce/repeat/seek timing rules with plain arithmetic.
module tb_spaceship_turn_ctrl;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int SG = 4;

    logic       clk, rst, btn_cw, btn_ccw, auto_en, auto_req;
    logic [3:0] auto_target, angle_in;
    logic       turn_cw, turn_ccw, busy, auto_done, auto_abort;

    spaceship_turn_ctrl #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .STEP_GAP(SG)
    ) dut (
        .clk(clk), .rst(rst), .btn_cw(btn_cw), .btn_ccw(btn_ccw),
        .auto_en(auto_en), .auto_req(auto_req), .auto_target(auto_target),
        .angle_in(angle_in), .turn_cw(turn_cw), .turn_ccw(turn_ccw), .busy(busy),
        .auto_done(auto_done), .auto_abort(auto_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0, last_pulse = -1000, heading = 0;
    int pulse_t[$];
    int pulse_cw[$];
    int done_t[$];
    int abort_t[$];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // one clock; sample registered outputs just after the edge and play the angle block
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (turn_cw || turn_ccw) begin
            chk("cw_ccw_exclusive", int'(turn_cw & turn_ccw), 0);
            chk("pulse_spacing_ok", int'((cyc - last_pulse) >= SG), 1);
            last_pulse = cyc;
            pulse_t.push_back(cyc);
            pulse_cw.push_back(int'(turn_cw));
            if (turn_cw) heading = (heading + 1) % 16;
            else         heading = (heading + 15) % 16;
            angle_in = 4'(heading);
        end
        if (auto_done)  done_t.push_back(cyc);
        if (auto_abort) abort_t.push_back(cyc);
    endtask

    task automatic clear_log();
        pulse_t.delete();
        pulse_cw.delete();
        done_t.delete();
        abort_t.delete();
    endtask

    task automatic set_heading(input int h);
        heading  = h;
        angle_in = 4'(h);
    endtask

    task automatic run_seek(input int start, input int target, input bit poke);
        int d, nsteps, cw_dir, n, t_end;
        set_heading(start);
        d      = (target - start + 16) % 16;
        cw_dir = (d <= 8) ? 1 : 0;
        nsteps = (d <= 8) ? d : 16 - d;
        t_end  = 2 + SG * nsteps;
        clear_log();
        n = cyc;
        auto_en = 1'b1; auto_target = 4'(target); auto_req = 1'b1;
        step();
        auto_req = 1'b0;
        chk("seek_busy", int'(busy), 1);
        while (cyc - n < t_end + 3) begin
            // a request while busy must not disturb the latched target
            if (poke && cyc - n == 3) begin
                auto_target = 4'((target + 8) % 16);
                auto_req    = 1'b1;
            end
            step();
            auto_req = 1'b0;
        end
        chk("seek_npulse", pulse_t.size(), nsteps);
        foreach (pulse_t[i]) begin
            chk("seek_pulse_time", pulse_t[i] - n, 2 + SG * i);
            chk("seek_pulse_dir", pulse_cw[i], cw_dir);
        end
        chk("seek_ndone", done_t.size(), 1);
        if (done_t.size() > 0) chk("seek_done_time", done_t[0] - n, t_end);
        chk("seek_noabort", abort_t.size(), 0);
        chk("seek_heading", heading, target);
        chk("seek_busy_end", int'(busy), 0);
    endtask

    initial begin
        int k, n, l1, l2, exp_n, ab_off, t;
        int hold_exp[$];

        rst = 1'b1; btn_cw = 1'b0; btn_ccw = 1'b0; auto_en = 1'b0; auto_req = 1'b0;
        auto_target = 4'd0; angle_in = 4'd0;
        repeat (3) step();
        chk("rst_cw", int'(turn_cw), 0);
        chk("rst_ccw", int'(turn_ccw), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(auto_done), 0);
        chk("rst_abort", int'(auto_abort), 0);
        rst = 1'b0;
        repeat (3) step();

        // tap with sub-threshold glitches around a stable press
        clear_log();
        l1 = $urandom_range(1, D - 1);
        l2 = $urandom_range(1, D - 1);
        btn_cw = 1'b1; repeat (l1) step(); btn_cw = 1'b0; repeat (8) step();
        k = cyc;
        btn_cw = 1'b1; repeat (10) step(); btn_cw = 1'b0; repeat (8) step();
        btn_cw = 1'b1; repeat (l2) step(); btn_cw = 1'b0; repeat (20) step();
        chk("tap_npulse", pulse_t.size(), 1);
        if (pulse_t.size() > 0) begin
            chk("tap_time", pulse_t[0] - k, 3 + D);
            chk("tap_dir", pulse_cw[0], 1);
        end
        chk("tap_busy_end", int'(busy), 0);

        // hold-to-repeat: first pulse, then DELAY, then PERIOD while the level stays high
        clear_log();
        t = 3 + D;
        hold_exp.push_back(t);
        t += RD;
        while (t <= 60 + 2 + D) begin
            hold_exp.push_back(t);
            t += RP;
        end
        k = cyc;
        btn_ccw = 1'b1; repeat (60) step(); btn_ccw = 1'b0; repeat (30) step();
        chk("hold_npulse", pulse_t.size(), hold_exp.size());
        foreach (pulse_t[i]) begin
            if (i < hold_exp.size()) chk("hold_time", pulse_t[i] - k, hold_exp[i]);
            chk("hold_dir", pulse_cw[i], 0);
        end
        chk("hold_busy_end", int'(busy), 0);

        // both buttons together
        clear_log();
        btn_cw = 1'b1; btn_ccw = 1'b1; repeat (20) step();
        btn_cw = 1'b0; btn_ccw = 1'b0; repeat (12) step();
        chk("both_npulse", pulse_t.size(), 0);
        chk("both_busy", int'(busy), 0);

        // directed seeks incl. wrap and d=8 ties, then random ones
        run_seek(14, 2, 1'b0);
        run_seek(14, 6, 1'b1);
        run_seek(2, 10, 1'b0);
        run_seek(5, 5, 1'b0);
        for (int i = 0; i < 6; i++) begin
            int s, tg, dd;
            s  = $urandom_range(0, 15);
            tg = $urandom_range(0, 15);
            dd = (tg - s + 16) % 16;
            run_seek(s, tg, (dd >= 2 && dd <= 14) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        // abort by manual press after the second step
        set_heading(0);
        clear_log();
        n = cyc;
        auto_en = 1'b1; auto_target = 4'd6; auto_req = 1'b1;
        step();
        auto_req = 1'b0;
        while (cyc - n < 6) step();
        btn_cw = 1'b1;
        ab_off = 6 + 3 + D;
        exp_n = 0;
        for (int i = 0; i < 6; i++) if (2 + SG * i < ab_off) exp_n++;
        repeat (ab_off + 10 - 6) step();
        btn_cw = 1'b0;
        repeat (15) step();
        chk("abtn_nabort", abort_t.size(), 1);
        if (abort_t.size() > 0) chk("abtn_abort_time", abort_t[0] - n, ab_off);
        chk("abtn_npulse", pulse_t.size(), exp_n);
        chk("abtn_nodone", done_t.size(), 0);
        chk("abtn_busy", int'(busy), 0);

        // abort by dropping auto_en inside the gap
        set_heading(0);
        clear_log();
        n = cyc;
        auto_en = 1'b1; auto_target = 4'd6; auto_req = 1'b1;
        step();
        auto_req = 1'b0;
        step();
        auto_en = 1'b0;
        repeat (15) step();
        chk("aen_nabort", abort_t.size(), 1);
        if (abort_t.size() > 0) chk("aen_abort_time", abort_t[0] - n, 3);
        chk("aen_npulse", pulse_t.size(), 1);
        chk("aen_nodone", done_t.size(), 0);

        // request with autopilot disabled is dropped
        clear_log();
        auto_en = 1'b0; auto_target = 4'd9; auto_req = 1'b1;
        step();
        auto_req = 1'b0;
        chk("dis_busy", int'(busy), 0);
        repeat (6) step();
        chk("dis_npulse", pulse_t.size(), 0);
        chk("dis_ndone", done_t.size(), 0);

        // reset while in repeat mode
        clear_log();
        btn_cw = 1'b1;
        repeat (12) step();
        chk("rrep_busy_before", int'(busy), 1);
        rst = 1'b1; btn_cw = 1'b0;
        step();
        chk("rrep_cw", int'(turn_cw), 0);
        chk("rrep_ccw", int'(turn_ccw), 0);
        chk("rrep_busy", int'(busy), 0);
        chk("rrep_done", int'(auto_done), 0);
        chk("rrep_abort", int'(auto_abort), 0);
        rst = 1'b0;
        repeat (30) step();
        chk("rrep_npulse", pulse_t.size(), 1);
        chk("rrep_nabort", abort_t.size(), 0);

        // reset while seeking: no abort pulse, nothing further
        set_heading(0);
        clear_log();
        auto_en = 1'b1; auto_target = 4'd5; auto_req = 1'b1;
        step();
        auto_req = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rseek_busy", int'(busy), 0);
        repeat (12) step();
        chk("rseek_npulse", pulse_t.size(), 1);
        chk("rseek_nabort", abort_t.size(), 0);
        chk("rseek_ndone", done_t.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
